rs_dispatch: RTL and testbench



---
 rtl/rs_dispatch.sv | 243 ++++++++++++++++++++++++
 tb/tb_rs_dispatch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_dispatch.sv
// rs_dispatch: issue-side front end of the reservation station.
//
// Takes decoded, ROB-tagged instructions and resolves their source operands
// from the register file, the ROB and the ALU/LSB result broadcasts. They are
// buffered in a 2-entry in-order queue, and each waiting entry keeps snooping
// the broadcasts. The queue head drives the RS insert port and leaves the
// queue only when the RS is not full.
//
// Ports:
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   rdy_in                    global ready; low freezes all state
//   clear_flag                synchronous flush (mispredict)
//   dec_valid / dec_ready     decoder handshake
//   dec_*                     decoded fields and operand lookup results
//   rs_* / lsb_*              ALU and LSB result broadcasts
//   full                      RS has no free slot
//   inst_valid, ins_*, is_Q*, Q*, Imm_in, Pc_in, ROB_id
//                             RS insert port, driven from the queue head
module rs_dispatch #(
  parameter int unsigned TYPE_W = 7,
  parameter int unsigned ROB_W  = 5,
  parameter int unsigned DEPTH  = 2   // fixed at 2 for this revision
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              clear_flag,
  // decoder side
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [TYPE_W-1:0] dec_type,
  input  logic              dec_itype,
  input  logic [31:0]       dec_imm,
  input  logic [31:0]       dec_pc,
  input  logic [ROB_W-1:0]  dec_rob_id,
  input  logic              dec_use1,
  input  logic              dec_use2,
  input  logic              dec_busy1,
  input  logic              dec_busy2,
  input  logic [ROB_W-1:0]  dec_tag1,
  input  logic [ROB_W-1:0]  dec_tag2,
  input  logic [31:0]       dec_rfv1,
  input  logic [31:0]       dec_rfv2,
  input  logic              dec_robr1,
  input  logic              dec_robr2,
  input  logic [31:0]       dec_robv1,
  input  logic [31:0]       dec_robv2,
  // result broadcasts
  input  logic              rs_ready,
  input  logic [ROB_W-1:0]  rs_ROB_id,
  input  logic [31:0]       rs_val,
  input  logic              lsb_ready,
  input  logic [ROB_W-1:0]  lsb_rob_id,
  input  logic [31:0]       lsb_val,
  // RS insert port
  input  logic              full,
  output logic              inst_valid,
  output logic [TYPE_W-1:0] ins_Type,
  output logic [31:0]       ins_rs1,
  output logic [31:0]       ins_rs2,
  output logic              is_Qi,
  output logic              is_Qj,
  output logic [ROB_W-1:0]  Qi,
  output logic [ROB_W-1:0]  Qj,
  output logic              ins_Itype,
  output logic [31:0]       Imm_in,
  output logic [31:0]       Pc_in,
  output logic [ROB_W-1:0]  ROB_id
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]      val;
    logic             pend;
    logic [ROB_W-1:0] tag;
  } opnd_t;

  typedef struct packed {
    logic              v;
    logic [TYPE_W-1:0] typ;
    logic              itype;
    logic [31:0]       imm;
    logic [31:0]       pc;
    logic [ROB_W-1:0]  rob;
    opnd_t             op1;
    opnd_t             op2;
  } entry_t;

  // Operand lookup at accept time; first matching source wins.
  function automatic opnd_t resolve(input logic             src_used,
                                    input logic             busy,
                                    input logic [ROB_W-1:0] tag,
                                    input logic [31:0]      rfv,
                                    input logic             robr,
                                    input logic [31:0]      robv);
    opnd_t o;
    o = '0;
    if (!src_used) begin
      o = '0;
    end else if (!busy) begin
      o.val = rfv;
    end else if (robr) begin
      o.val = robv;
    end else if (lsb_ready && (lsb_rob_id == tag)) begin
      o.val = lsb_val;
    end else if (rs_ready && (rs_ROB_id == tag)) begin
      o.val = rs_val;
    end else begin
      o.pend = 1'b1;
      o.tag  = tag;
    end
    return o;
  endfunction

  // Broadcast capture for a waiting operand; LSB wins over ALU.
  function automatic opnd_t snoop_op(input opnd_t o);
    opnd_t r;
    r = o;
    if (o.pend) begin
      if (lsb_ready && (lsb_rob_id == o.tag)) begin
        r = '{val: lsb_val, pend: 1'b0, tag: '0};
      end else if (rs_ready && (rs_ROB_id == o.tag)) begin
        r = '{val: rs_val, pend: 1'b0, tag: '0};
      end
    end
    return r;
  endfunction

  function automatic entry_t snoop_ent(input entry_t e);
    entry_t r;
    r = e;
    if (e.v) begin
      r.op1 = snoop_op(e.op1);
      r.op2 = snoop_op(e.op2);
    end
    return r;
  endfunction

  entry_t          r_e0, r_e1;
  logic [CntW-1:0] r_cnt;

  entry_t          w_e0_nxt, w_e1_nxt;
  entry_t          w_snp0, w_snp1, w_new;
  logic [CntW-1:0] w_cnt_nxt;
  logic            w_issue, w_accept, w_slot0;

  assign w_issue  = r_e0.v & ~full & rdy_in & ~clear_flag;
  // Gated by reset so the decoder never sees a handshake while in reset.
  assign dec_ready = rst_n_in & rdy_in & ~clear_flag &
                     ((r_cnt < CntW'(DEPTH)) | w_issue);
  assign w_accept = dec_valid & dec_ready;
  assign inst_valid = w_issue;

  always_comb begin
    w_snp0 = snoop_ent(r_e0);
    w_snp1 = snoop_ent(r_e1);
    w_new        = '0;
    w_new.v      = 1'b1;
    w_new.typ    = dec_type;
    w_new.itype  = dec_itype;
    w_new.imm    = dec_imm;
    w_new.pc     = dec_pc;
    w_new.rob    = dec_rob_id;
    w_new.op1    = resolve(dec_use1, dec_busy1, dec_tag1, dec_rfv1, dec_robr1, dec_robv1);
    w_new.op2    = resolve(dec_use2, dec_busy2, dec_tag2, dec_rfv2, dec_robr2, dec_robv2);
  end

  // New entry lands at slot cnt, or cnt-1 when the head leaves on the same edge.
  assign w_slot0 = w_issue ? (r_cnt == CntW'(1)) : (r_cnt == '0);

  always_comb begin
    w_e0_nxt  = r_e0;
    w_e1_nxt  = r_e1;
    w_cnt_nxt = r_cnt;
    if (rdy_in) begin
      if (clear_flag) begin
        w_e0_nxt  = '0;
        w_e1_nxt  = '0;
        w_cnt_nxt = '0;
      end else begin
        w_e0_nxt = w_snp0;
        w_e1_nxt = w_snp1;
        if (w_issue) begin
          w_e0_nxt = w_snp1;
          w_e1_nxt = '0;
        end
        if (w_accept) begin
          if (w_slot0) begin
            w_e0_nxt = w_new;
          end else begin
            w_e1_nxt = w_new;
          end
        end
        unique case ({w_issue, w_accept})
          2'b10:   w_cnt_nxt = r_cnt - CntW'(1);
          2'b01:   w_cnt_nxt = r_cnt + CntW'(1);
          default: w_cnt_nxt = r_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_cnt <= '0;
    end else begin
      r_e0  <= w_e0_nxt;
      r_e1  <= w_e1_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    ins_Type  = '0;
    ins_rs1   = '0;
    ins_rs2   = '0;
    is_Qi     = 1'b0;
    is_Qj     = 1'b0;
    Qi        = '0;
    Qj        = '0;
    ins_Itype = 1'b0;
    Imm_in    = '0;
    Pc_in     = '0;
    ROB_id    = '0;
    if (r_e0.v) begin
      ins_Type  = r_e0.typ;
      ins_rs1   = r_e0.op1.val;
      ins_rs2   = r_e0.op2.val;
      is_Qi     = r_e0.op1.pend;
      is_Qj     = r_e0.op2.pend;
      Qi        = r_e0.op1.tag;
      Qj        = r_e0.op2.tag;
      ins_Itype = r_e0.itype;
      Imm_in    = r_e0.imm;
      Pc_in     = r_e0.pc;
      ROB_id    = r_e0.rob;
    end
  end

endmodule

// File: tb/tb_rs_dispatch.sv
module tb_rs_dispatch;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in, clear_flag;
  logic        dec_valid, dec_ready;
  logic [6:0]  dec_type;
  logic        dec_itype;
  logic [31:0] dec_imm, dec_pc;
  logic [4:0]  dec_rob_id;
  logic        dec_use1, dec_use2, dec_busy1, dec_busy2;
  logic [4:0]  dec_tag1, dec_tag2;
  logic [31:0] dec_rfv1, dec_rfv2;
  logic        dec_robr1, dec_robr2;
  logic [31:0] dec_robv1, dec_robv2;
  logic        rs_ready;
  logic [4:0]  rs_ROB_id;
  logic [31:0] rs_val;
  logic        lsb_ready;
  logic [4:0]  lsb_rob_id;
  logic [31:0] lsb_val;
  logic        full;
  logic        inst_valid;
  logic [6:0]  ins_Type;
  logic [31:0] ins_rs1, ins_rs2;
  logic        is_Qi, is_Qj;
  logic [4:0]  Qi, Qj;
  logic        ins_Itype;
  logic [31:0] Imm_in, Pc_in;
  logic [4:0]  ROB_id;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  rs_dispatch dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_type(dec_type),
    .dec_itype(dec_itype), .dec_imm(dec_imm), .dec_pc(dec_pc), .dec_rob_id(dec_rob_id),
    .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_busy1(dec_busy1), .dec_busy2(dec_busy2),
    .dec_tag1(dec_tag1), .dec_tag2(dec_tag2), .dec_rfv1(dec_rfv1), .dec_rfv2(dec_rfv2),
    .dec_robr1(dec_robr1), .dec_robr2(dec_robr2), .dec_robv1(dec_robv1),
    .dec_robv2(dec_robv2), .rs_ready(rs_ready), .rs_ROB_id(rs_ROB_id), .rs_val(rs_val),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_val(lsb_val), .full(full),
    .inst_valid(inst_valid), .ins_Type(ins_Type), .ins_rs1(ins_rs1), .ins_rs2(ins_rs2),
    .is_Qi(is_Qi), .is_Qj(is_Qj), .Qi(Qi), .Qj(Qj), .ins_Itype(ins_Itype),
    .Imm_in(Imm_in), .Pc_in(Pc_in), .ROB_id(ROB_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks run 1 ns later.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_dec();
    dec_valid = 0; dec_type = '0; dec_itype = 0; dec_imm = '0; dec_pc = '0;
    dec_rob_id = '0; dec_use1 = 0; dec_use2 = 0; dec_busy1 = 0; dec_busy2 = 0;
    dec_tag1 = '0; dec_tag2 = '0; dec_rfv1 = '0; dec_rfv2 = '0;
    dec_robr1 = 0; dec_robr2 = 0; dec_robv1 = '0; dec_robv2 = '0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] rob);
    idle_dec();
    dec_valid = 1; dec_pc = pc; dec_rob_id = rob;
  endtask

  initial begin
    rst_n_in = 0; rdy_in = 1; clear_flag = 0; full = 0;
    rs_ready = 0; rs_ROB_id = '0; rs_val = '0;
    lsb_ready = 0; lsb_rob_id = '0; lsb_val = '0;
    idle_dec();
    settle();
    chk("rst_dec_ready", 32'(dec_ready), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    tick(); tick();
    rst_n_in = 1;
    settle();
    chk("post_rst_dec_ready", 32'(dec_ready), 1);
    chk("post_rst_inst_valid", 32'(inst_valid), 0);

    // Register-file operand, one-cycle insert latency.
    offer(32'h100, 5'd1);
    dec_type = 7'h13; dec_itype = 1; dec_imm = 32'd5;
    dec_use1 = 1; dec_busy1 = 0; dec_rfv1 = 32'd7;
    settle();
    chk("a_accept_ready", 32'(dec_ready), 1);
    chk("a_no_early_issue", 32'(inst_valid), 0);
    tick(); idle_dec(); settle();
    chk("a_inst_valid", 32'(inst_valid), 1);
    chk("a_rs1", ins_rs1, 32'd7);
    chk("a_is_Qi", 32'(is_Qi), 0);
    chk("a_pc", Pc_in, 32'h100);
    chk("a_type", 32'(ins_Type), 32'h13);
    chk("a_imm", Imm_in, 32'd5);
    chk("a_itype", 32'(ins_Itype), 1);
    chk("a_rob", 32'(ROB_id), 32'd1);
    chk("a_rs2_unused", ins_rs2, 0);
    tick(); settle();
    chk("a_empty_valid", 32'(inst_valid), 0);
    chk("a_empty_pc", Pc_in, 0);

    // Pending rs1 captured from ALU broadcast; rs2 taken from the ROB.
    full = 1;
    offer(32'h200, 5'd2);
    dec_use1 = 1; dec_busy1 = 1; dec_tag1 = 5'd3;
    dec_use2 = 1; dec_busy2 = 1; dec_tag2 = 5'd6; dec_robr2 = 1; dec_robv2 = 32'h77;
    tick(); idle_dec(); settle();
    chk("b_full_no_issue", 32'(inst_valid), 0);
    chk("b_is_Qi", 32'(is_Qi), 1);
    chk("b_Qi", 32'(Qi), 3);
    chk("b_rs1_pending", ins_rs1, 0);
    chk("b_rs2_rob", ins_rs2, 32'h77);
    chk("b_is_Qj", 32'(is_Qj), 0);
    rs_ready = 1; rs_ROB_id = 5'd3; rs_val = 32'h55;
    tick(); rs_ready = 0; settle();
    chk("b_snoop_is_Qi", 32'(is_Qi), 0);
    chk("b_snoop_Qi", 32'(Qi), 0);
    chk("b_snoop_rs1", ins_rs1, 32'h55);

    // Second entry pending on tag 4; simultaneous LSB/ALU broadcast on 4.
    offer(32'h300, 5'd7);
    dec_use1 = 1; dec_busy1 = 1; dec_tag1 = 5'd4;
    tick(); idle_dec(); settle();
    chk("c_full_dec_ready", 32'(dec_ready), 0);
    chk("c_head_held", Pc_in, 32'h200);
    lsb_ready = 1; lsb_rob_id = 5'd4; lsb_val = 32'hA;
    rs_ready = 1; rs_ROB_id = 5'd4; rs_val = 32'hB;
    tick(); lsb_ready = 0; rs_ready = 0;
    full = 0; settle();
    chk("c_issue_first", 32'(inst_valid), 1);
    chk("c_issue_first_pc", Pc_in, 32'h200);
    full = 1;
    // Accept-cycle ALU broadcast resolves the new operand (tag 9).
    offer(32'h400, 5'd8);
    dec_use1 = 1; dec_busy1 = 1; dec_tag1 = 5'd9;
    rs_ready = 1; rs_ROB_id = 5'd9; rs_val = 32'h99;
    full = 0;
    tick(); idle_dec(); rs_ready = 0; full = 1; settle();
    chk("c_lsb_priority", ins_rs1, 32'hA);
    chk("c_second_pc", Pc_in, 32'h300);
    chk("c_second_is_Qi", 32'(is_Qi), 0);
    full = 0;
    tick(); settle();
    chk("d_fwd_pc", Pc_in, 32'h400);
    chk("d_fwd_rs1", ins_rs1, 32'h99);
    chk("d_fwd_is_Qi", 32'(is_Qi), 0);
    tick(); settle();
    chk("d_empty", 32'(inst_valid), 0);

    // Three offered against a full RS: two taken, then back-pressure.
    full = 1;
    offer(32'h500, 5'd10); settle();
    chk("e_ready0", 32'(dec_ready), 1);
    tick(); offer(32'h504, 5'd11); settle();
    chk("e_ready1", 32'(dec_ready), 1);
    tick(); offer(32'h508, 5'd12); settle();
    chk("e_ready2", 32'(dec_ready), 0);
    tick(); settle();
    chk("e_still_blocked", 32'(dec_ready), 0);
    full = 0; settle();
    chk("e_issue_500", Pc_in, 32'h500);
    chk("e_ready_on_issue", 32'(dec_ready), 1);
    tick(); idle_dec(); settle();
    chk("e_issue_504", Pc_in, 32'h504);
    tick(); settle();
    chk("e_issue_508", Pc_in, 32'h508);
    chk("e_rob_508", 32'(ROB_id), 32'd12);
    full = 1;
    tick(); settle();
    chk("e_stalled_508", Pc_in, 32'h508);

    // Fill to two, freeze with rdy_in low, then flush.
    offer(32'h600, 5'd13);
    tick(); idle_dec(); settle();
    chk("f_full_ready", 32'(dec_ready), 0);
    rdy_in = 0; full = 0; offer(32'h700, 5'd14); settle();
    chk("f_frz_valid", 32'(inst_valid), 0);
    chk("f_frz_ready", 32'(dec_ready), 0);
    tick(); tick(); idle_dec(); rdy_in = 1; full = 1; settle();
    chk("f_frz_pc", Pc_in, 32'h508);
    chk("f_frz_cnt2", 32'(dec_ready), 0);
    clear_flag = 1; full = 0; settle();
    chk("f_clr_valid", 32'(inst_valid), 0);
    chk("f_clr_ready", 32'(dec_ready), 0);
    tick(); clear_flag = 0; settle();
    chk("f_clr_next_valid", 32'(inst_valid), 0);
    chk("f_clr_pc", Pc_in, 0);
    chk("f_clr_ready_back", 32'(dec_ready), 1);

    // Asynchronous reset with two entries queued.
    full = 1;
    offer(32'h700, 5'd15); tick();
    offer(32'h704, 5'd16); tick(); idle_dec(); settle();
    chk("g_two_queued", Pc_in, 32'h700);
    #1 rst_n_in = 0;
    #1;
    chk("g_rst_pc", Pc_in, 0);
    chk("g_rst_rob", 32'(ROB_id), 0);
    chk("g_rst_ready", 32'(dec_ready), 0);
    chk("g_rst_valid", 32'(inst_valid), 0);
    tick();
    #2 rst_n_in = 1; full = 0;
    #1;
    chk("g_rel_ready", 32'(dec_ready), 1);
    chk("g_rel_valid", 32'(inst_valid), 0);
    tick(); settle();
    chk("g_rel_no_strobe", 32'(inst_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
